// File: rtl/exbus_cycle_ctrl.sv
// External 8-bit bus cycle engine: turns one sequencer request into a
// SETUP/STROBE/WAIT/HOLD read or write cycle with wait states and a timeout.
module exbus_cycle_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int TIMEOUT     = 255,
  parameter int AW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          fetch,
  input  logic [3:0]    exbusCtrl,
  input  logic [AW-1:0] pcAddr,
  input  logic [AW-1:0] marAddr,
  input  logic [7:0]    wdata,
  input  logic          busWait,
  input  logic [7:0]    busDin,
  output logic [AW-1:0] busAddr,
  output logic [7:0]    busDout,
  output logic          busOE,
  output logic          nRD,
  output logic          nWR,
  output logic          ioSel,
  output logic [7:0]    rdata,
  output logic          done,
  output logic          busy,
  output logic          pcInc,
  output logic          busErr
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_HOLD
  } state_t;

  localparam logic [3:0] WC_LOAD = 4'(WAIT_CYCLES);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [7:0]    r_tcnt;
  logic          r_rd;
  logic          r_fetch;

  logic          w_rd;
  logic          w_wr;
  logic          w_ill;
  logic          w_io;
  logic [AW-1:0] w_addr;

  // A fetch overrides exbusCtrl entirely: memory-space read from the PC.
  assign w_rd   = fetch | (exbusCtrl[0] & ~exbusCtrl[1]);
  assign w_wr   = ~fetch & ~exbusCtrl[0] & exbusCtrl[1];
  assign w_ill  = ~fetch & exbusCtrl[0] & exbusCtrl[1];
  assign w_io   = ~fetch & exbusCtrl[3];
  assign w_addr = (!fetch && exbusCtrl[2]) ? marAddr : pcAddr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_rd    <= 1'b0;
      r_fetch <= 1'b0;
      busAddr <= '0;
      busDout <= '0;
      busOE   <= 1'b0;
      nRD     <= 1'b1;
      nWR     <= 1'b1;
      ioSel   <= 1'b0;
      rdata   <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      pcInc   <= 1'b0;
      busErr  <= 1'b0;
    end else begin
      done  <= 1'b0;
      pcInc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_ill) begin
              busErr <= 1'b1;
            end else if (w_rd || w_wr) begin
              r_state <= S_SETUP;
              r_rd    <= w_rd;
              r_fetch <= fetch;
              busy    <= 1'b1;
              busAddr <= w_addr;
              ioSel   <= w_io;
              busOE   <= w_wr;
              if (w_wr) busDout <= wdata;
            end
          end
        end
        S_SETUP: begin
          nRD     <= ~r_rd;
          nWR     <= r_rd;
          r_cnt   <= WC_LOAD;
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (busWait) begin
            r_tcnt  <= '0;
            r_state <= S_WAIT;
          end else begin
            nRD     <= 1'b1;
            nWR     <= 1'b1;
            done    <= 1'b1;
            pcInc   <= r_fetch;
            r_state <= S_HOLD;
            if (r_rd) rdata <= busDin;
          end
        end
        // Abort releases the strobe without capturing data but still signals done.
        S_WAIT: begin
          if (!busWait || (r_tcnt == TO_LAST)) begin
            nRD     <= 1'b1;
            nWR     <= 1'b1;
            done    <= 1'b1;
            pcInc   <= r_fetch;
            r_state <= S_HOLD;
            if (busWait) busErr <= 1'b1;
            else if (r_rd) rdata <= busDin;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        S_HOLD: begin
          busy    <= 1'b0;
          busOE   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exbus_cycle_ctrl.sv
// Bench for exbus_cycle_ctrl: phase-based transaction model checked every cycle,
// plus hand-computed expectations for each directed scenario.
module tb_exbus_cycle_ctrl;
  localparam int AW       = 16;
  localparam int WC       = 1;
  localparam int TO_MAIN  = 255;
  localparam int TO_SHORT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          fetch = 1'b0;
  logic [3:0]    exbusCtrl = '0;
  logic [AW-1:0] pcAddr = '0;
  logic [AW-1:0] marAddr = '0;
  logic [7:0]    wdata = '0;
  logic          busWait = 1'b0;
  logic [7:0]    busDin = '0;

  logic [AW-1:0] busAddr;
  logic [7:0]    busDout, rdata;
  logic          busOE, nRD, nWR, ioSel, done, busy, pcInc, busErr;

  logic [AW-1:0] t_busAddr;
  logic [7:0]    t_busDout, t_rdata;
  logic          t_busOE, t_nRD, t_nWR, t_ioSel, t_done, t_busy, t_pcInc, t_busErr;

  exbus_cycle_ctrl #(.WAIT_CYCLES(WC), .TIMEOUT(TO_MAIN), .AW(AW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .fetch(fetch), .exbusCtrl(exbusCtrl),
    .pcAddr(pcAddr), .marAddr(marAddr), .wdata(wdata), .busWait(busWait), .busDin(busDin),
    .busAddr(busAddr), .busDout(busDout), .busOE(busOE), .nRD(nRD), .nWR(nWR),
    .ioSel(ioSel), .rdata(rdata), .done(done), .busy(busy), .pcInc(pcInc), .busErr(busErr));

  exbus_cycle_ctrl #(.WAIT_CYCLES(WC), .TIMEOUT(TO_SHORT), .AW(AW)) u_dut_to (
    .clk(clk), .reset(reset), .start(start), .fetch(fetch), .exbusCtrl(exbusCtrl),
    .pcAddr(pcAddr), .marAddr(marAddr), .wdata(wdata), .busWait(busWait), .busDin(busDin),
    .busAddr(t_busAddr), .busDout(t_busDout), .busOE(t_busOE), .nRD(t_nRD), .nWR(t_nWR),
    .ioSel(t_ioSel), .rdata(t_rdata), .done(t_done), .busy(t_busy), .pcInc(t_pcInc),
    .busErr(t_busErr));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: a transaction is described by its phase (cycles since acceptance).
  // Phase 1 is address setup, phases >= 2 have the strobe low; the strobe is
  // released at the end of a phase >= WC+2 when busWait is low, or when the
  // extension beyond WC+2 reaches the timeout. One hold cycle follows.
  logic [AW-1:0] e_busAddr;
  logic [7:0]    e_busDout, e_rdata;
  logic          e_busOE, e_nRD, e_nWR, e_ioSel, e_done, e_busy, e_pcInc, e_busErr;
  bit            m_act, m_hold, m_rd, m_fetch;
  int            m_ph;

  logic d_rd, d_wr, d_ill;
  assign d_rd  = fetch || (exbusCtrl[0] && !exbusCtrl[1]);
  assign d_wr  = !fetch && !exbusCtrl[0] && exbusCtrl[1];
  assign d_ill = !fetch && exbusCtrl[0] && exbusCtrl[1];

  always @(posedge clk) begin
    if (reset) begin
      e_busAddr <= '0; e_busDout <= '0; e_rdata <= '0;
      e_busOE <= 0; e_nRD <= 1; e_nWR <= 1; e_ioSel <= 0;
      e_done <= 0; e_busy <= 0; e_pcInc <= 0; e_busErr <= 0;
      m_act <= 0; m_hold <= 0; m_ph <= 0; m_rd <= 0; m_fetch <= 0;
    end else begin
      e_done  <= 0;
      e_pcInc <= 0;
      if (m_hold) begin
        e_busy <= 0; e_busOE <= 0; m_hold <= 0; m_act <= 0;
      end else if (m_act) begin
        if (m_ph == 1) begin
          if (m_rd) e_nRD <= 0; else e_nWR <= 0;
          m_ph <= 2;
        end else if (m_ph >= WC + 2 && (!busWait || (m_ph - (WC + 2)) == TO_MAIN)) begin
          e_nRD <= 1; e_nWR <= 1; e_done <= 1; e_pcInc <= m_fetch; m_hold <= 1;
          if (busWait) e_busErr <= 1;
          else if (m_rd) e_rdata <= busDin;
        end else begin
          m_ph <= m_ph + 1;
        end
      end else if (start) begin
        if (d_ill) e_busErr <= 1;
        else if (d_rd || d_wr) begin
          m_act <= 1; m_ph <= 1; m_rd <= d_rd; m_fetch <= fetch;
          e_busy <= 1; e_ioSel <= !fetch && exbusCtrl[3];
          e_busAddr <= (!fetch && exbusCtrl[2]) ? marAddr : pcAddr;
          e_busOE <= d_wr;
          if (d_wr) e_busDout <= wdata;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busAddr", 32'(busAddr), 32'(e_busAddr));
      chk("busDout", 32'(busDout), 32'(e_busDout));
      chk("rdata",   32'(rdata),   32'(e_rdata));
      chk("busOE",   32'(busOE),   32'(e_busOE));
      chk("nRD",     32'(nRD),     32'(e_nRD));
      chk("nWR",     32'(nWR),     32'(e_nWR));
      chk("ioSel",   32'(ioSel),   32'(e_ioSel));
      chk("done",    32'(done),    32'(e_done));
      chk("busy",    32'(busy),    32'(e_busy));
      chk("pcInc",   32'(pcInc),   32'(e_pcInc));
      chk("busErr",  32'(busErr),  32'(e_busErr));
      chk("strobe_excl", 32'(!nRD && !nWR), 32'(0));
      chk("oe_on_read",  32'(busOE && !nRD), 32'(0));
    end
  end

  logic          rc_nrd[32], rc_nwr[32], rc_done[32], rc_pcinc[32], rc_oe[32];
  logic          rc_busy[32], rc_err[32], rc_io[32];
  logic [7:0]    rc_rdata[32], rc_dout[32];
  logic [AW-1:0] rc_addr[32];
  logic          rt_nrd[32], rt_done[32], rt_err[32];
  logic [7:0]    rt_rdata[32];

  // Start asserted in cycle 0; busWait / reset scheduled on cycle ranges;
  // an optional second start (a fetch from BEEF) in cycle s2.
  task automatic run(input int n, input int wf, input int wt,
                     input int rf, input int rt, input int s2);
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rc_nrd[k] = nRD; rc_nwr[k] = nWR; rc_done[k] = done; rc_pcinc[k] = pcInc;
      rc_oe[k] = busOE; rc_busy[k] = busy; rc_err[k] = busErr; rc_io[k] = ioSel;
      rc_rdata[k] = rdata; rc_dout[k] = busDout; rc_addr[k] = busAddr;
      rt_nrd[k] = t_nRD; rt_done[k] = t_done; rt_err[k] = t_busErr; rt_rdata[k] = t_rdata;
      @(posedge clk); #1;
      start = (k + 1 == s2);
      if (k + 1 == s2) begin
        fetch = 1'b1;
        pcAddr = 16'hBEEF;
      end
      busWait = (k + 1 >= wf) && (k + 1 <= wt);
      reset   = (k + 1 >= rf) && (k + 1 <= rt);
    end
    start = 1'b0; busWait = 1'b0; reset = 1'b0; fetch = 1'b0;
  endtask

  function automatic int count_low_nrd(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (!rc_nrd[i]) c++;
    return c;
  endfunction

  function automatic int count_done(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (rc_done[i]) c++;
    return c;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cmp_en = 1'b1;
    chk("rst_nRD", 32'(nRD), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));

    // Reset in the middle of a write strobe
    exbusCtrl = 4'b0010; pcAddr = 16'h5555; wdata = 8'h81;
    run(8, -1, -1, 2, 4, -1);
    chk("c1_nWR_active", 32'(rc_nwr[2]), 32'(0));
    chk("c1_nWR_released", 32'(rc_nwr[3]), 32'(1));
    chk("c1_busy", 32'(rc_busy[3]), 32'(0));
    chk("c1_busOE", 32'(rc_oe[3]), 32'(0));
    chk("c1_busAddr", 32'(rc_addr[3]), 32'(0));
    chk("c1_busDout", 32'(rc_dout[3]), 32'(0));
    chk("c1_no_done", 32'(count_done(8)), 32'(0));

    // Fetch: exbusCtrl says IO write, but fetch must override it
    fetch = 1'b1; exbusCtrl = 4'b1010; pcAddr = 16'h1234; busDin = 8'hA5;
    run(8, -1, -1, -1, -1, -1);
    chk("c2_nRD_c1", 32'(rc_nrd[1]), 32'(1));
    chk("c2_nRD_c2", 32'(rc_nrd[2]), 32'(0));
    chk("c2_nRD_c3", 32'(rc_nrd[3]), 32'(0));
    chk("c2_nRD_c4", 32'(rc_nrd[4]), 32'(1));
    chk("c2_done_c3", 32'(rc_done[3]), 32'(0));
    chk("c2_done_c4", 32'(rc_done[4]), 32'(1));
    chk("c2_pcInc_c4", 32'(rc_pcinc[4]), 32'(1));
    chk("c2_rdata", 32'(rc_rdata[4]), 32'h000000A5);
    chk("c2_busAddr", 32'(rc_addr[4]), 32'h00001234);
    chk("c2_ioSel", 32'(rc_io[4]), 32'(0));
    chk("c2_busOE", 32'(rc_oe[2]), 32'(0));
    chk("c2_busy_c5", 32'(rc_busy[5]), 32'(0));

    // IO write from MAR
    exbusCtrl = 4'b1110; marAddr = 16'h00F0; wdata = 8'h3C;
    run(8, -1, -1, -1, -1, -1);
    chk("c3_busOE_c0", 32'(rc_oe[0]), 32'(0));
    chk("c3_busOE_c1", 32'(rc_oe[1]), 32'(1));
    chk("c3_nWR_c2", 32'(rc_nwr[2]), 32'(0));
    chk("c3_nWR_c3", 32'(rc_nwr[3]), 32'(0));
    chk("c3_nWR_c4", 32'(rc_nwr[4]), 32'(1));
    chk("c3_ioSel", 32'(rc_io[4]), 32'(1));
    chk("c3_done", 32'(rc_done[4]), 32'(1));
    chk("c3_pcInc", 32'(rc_pcinc[4]), 32'(0));
    chk("c3_busAddr", 32'(rc_addr[4]), 32'h000000F0);
    chk("c3_busDout", 32'(rc_dout[4]), 32'h0000003C);
    chk("c3_nRD_idle", 32'(count_low_nrd(8)), 32'(0));

    // Read extended by five busWait cycles
    fetch = 1'b1; pcAddr = 16'h2000; busDin = 8'h5A;
    run(12, 3, 7, -1, -1, -1);
    chk("c4_nRD_len", 32'(count_low_nrd(12)), 32'(7));
    chk("c4_done_c8", 32'(rc_done[8]), 32'(0));
    chk("c4_done_c9", 32'(rc_done[9]), 32'(1));
    chk("c4_rdata", 32'(rc_rdata[9]), 32'h0000005A);
    chk("c4_busErr", 32'(rc_err[10]), 32'(0));

    // Timeout on the TIMEOUT=4 instance, after a clean read loads rdata=77
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    fetch = 1'b1; pcAddr = 16'h3000; busDin = 8'h77;
    run(6, -1, -1, -1, -1, -1);
    fetch = 1'b1; busDin = 8'h99;
    run(16, 3, 12, -1, -1, -1);
    chk("c5_to_nRD_c7", 32'(rt_nrd[7]), 32'(0));
    chk("c5_to_nRD_c8", 32'(rt_nrd[8]), 32'(1));
    chk("c5_to_done_c8", 32'(rt_done[8]), 32'(1));
    chk("c5_to_busErr_c7", 32'(rt_err[7]), 32'(0));
    chk("c5_to_busErr_c9", 32'(rt_err[9]), 32'(1));
    chk("c5_to_rdata", 32'(rt_rdata[9]), 32'h00000077);
    chk("c5_main_nRD_len", 32'(count_low_nrd(16)), 32'(12));
    chk("c5_main_done_c14", 32'(rc_done[14]), 32'(1));
    chk("c5_main_rdata", 32'(rc_rdata[15]), 32'h00000099);
    chk("c5_main_busErr", 32'(rc_err[15]), 32'(0));

    // Illegal command, no-op command, then a start while busy
    fetch = 1'b0; exbusCtrl = 4'b0011;
    run(4, -1, -1, -1, -1, -1);
    chk("c6_ill_busy", 32'(rc_busy[1]), 32'(0));
    chk("c6_ill_busErr", 32'(rc_err[1]), 32'(1));
    chk("c6_ill_nostrobe", 32'(count_low_nrd(4)), 32'(0));
    chk("c6_ill_nodone", 32'(count_done(4)), 32'(0));
    exbusCtrl = 4'b0000;
    run(3, -1, -1, -1, -1, -1);
    chk("c6_nop_busy", 32'(rc_busy[1]), 32'(0));
    chk("c6_sticky", 32'(rc_err[2]), 32'(1));
    exbusCtrl = 4'b0101; marAddr = 16'h4242; busDin = 8'hC3;
    run(8, -1, -1, -1, -1, 2);
    chk("c6_ovl_addr", 32'(rc_addr[4]), 32'h00004242);
    chk("c6_ovl_done", 32'(rc_done[4]), 32'(1));
    chk("c6_ovl_once", 32'(count_done(8)), 32'(1));
    chk("c6_ovl_pcInc", 32'(rc_pcinc[4]), 32'(0));
    chk("c6_ovl_rdata", 32'(rc_rdata[4]), 32'h000000C3);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
